// File: rtl/ga_bus_master_if.sv
// Host request channel plus gate-array parallel bus, seen from the bus master.
// Signal suffixes follow the master's point of view.
interface ga_bus_master_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
);
  // host request / completion
  logic              req_i;
  logic              we_i;
  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] wdata_i;
  logic              busy_o;
  logic              ack_o;
  logic [DATA_W-1:0] rdata_o;
  // gate-array bus
  logic [ADDR_W-1:0] a_o;
  logic [DATA_W-1:0] d_out_o;
  logic              d_oe_o;
  logic [DATA_W-1:0] d_in_i;
  logic              ncs_o;
  logic              nwr_o;
  logic              nrd_o;

  modport master (
    input  req_i, we_i, addr_i, wdata_i, d_in_i,
    output busy_o, ack_o, rdata_o, a_o, d_out_o, d_oe_o, ncs_o, nwr_o, nrd_o
  );

  modport slave (
    output req_i, we_i, addr_i, wdata_i, d_in_i,
    input  busy_o, ack_o, rdata_o, a_o, d_out_o, d_oe_o, ncs_o, nwr_o, nrd_o
  );
endinterface

// File: rtl/ga_bus_master.sv
// Bus initiator for the sound gate array: turns single-cycle requests into
// registered nCS/nWR/nRD cycles with configurable setup, pulse and hold lengths.
module ga_bus_master #(
  parameter int ADDR_W    = 3,
  parameter int DATA_W    = 8,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic clk,
  input  logic rst,
  ga_bus_master_if.master bus
);

  if (SETUP_CYC < 1) begin : g_bad_setup
    $error("ga_bus_master: SETUP_CYC must be >= 1");
  end
  if (PULSE_CYC < 1) begin : g_bad_pulse
    $error("ga_bus_master: PULSE_CYC must be >= 1");
  end
  if (HOLD_CYC < 1) begin : g_bad_hold
    $error("ga_bus_master: HOLD_CYC must be >= 1");
  end

  localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_CYC = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  // The phase counter is loaded with N-1 on entry and the phase ends when it reads zero.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              we_q;
  logic [ADDR_W-1:0] a_q;
  logic [DATA_W-1:0] d_out_q;
  logic              d_oe_q;
  logic [DATA_W-1:0] rdata_q;
  logic              ncs_q;
  logic              nwr_q;
  logic              nrd_q;
  logic              ack_q;
  logic              busy_q;

  // NOTE: every state element, datapath included, sits on the async reset so
  // an aborted cycle leaves the bus idle at once; all updates use <= so each
  // branch sees the pre-edge values of every register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      a_q     <= '0;
      d_out_q <= '0;
      d_oe_q  <= 1'b0;
      rdata_q <= '0;
      ncs_q   <= 1'b1;
      nwr_q   <= 1'b1;
      nrd_q   <= 1'b1;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.req_i) begin
            state_q <= SETUP;
            cnt_q   <= SETUP_LD;
            we_q    <= bus.we_i;
            a_q     <= bus.addr_i;
            ncs_q   <= 1'b0;
            busy_q  <= 1'b1;
            if (bus.we_i) begin
              d_out_q <= bus.wdata_i;
              d_oe_q  <= 1'b1;
            end
          end
        end

        SETUP: begin
          if (cnt_q == '0) begin
            state_q <= STROBE;
            cnt_q   <= PULSE_LD;
            nwr_q   <= ~we_q;
            nrd_q   <= we_q;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        STROBE: begin
          if (cnt_q == '0) begin
            state_q <= HOLD;
            cnt_q   <= HOLD_LD;
            nwr_q   <= 1'b1;
            nrd_q   <= 1'b1;
            // nRD is still low at this edge, so the readback is stable
            if (!we_q) rdata_q <= bus.d_in_i;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        HOLD: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
            ncs_q   <= 1'b1;
            d_oe_q  <= 1'b0;
            ack_q   <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy_o  = busy_q;
  assign bus.ack_o   = ack_q;
  assign bus.rdata_o = rdata_q;
  assign bus.a_o     = a_q;
  assign bus.d_out_o = d_out_q;
  assign bus.d_oe_o  = d_oe_q;
  assign bus.ncs_o   = ncs_q;
  assign bus.nwr_o   = nwr_q;
  assign bus.nrd_o   = nrd_q;

endmodule

// File: tb/tb_ga_bus_master.sv
// Directed bench for ga_bus_master: default timing instance plus a stretched
// 3/4/2 instance, checked against hand-computed cycle-by-cycle expectations.
module tb_ga_bus_master;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  ga_bus_master_if #(.ADDR_W(3), .DATA_W(8)) bus0 ();
  ga_bus_master_if #(.ADDR_W(3), .DATA_W(8)) bus1 ();

  ga_bus_master #(
    .ADDR_W(3), .DATA_W(8), .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1)
  ) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.master)
  );

  ga_bus_master #(
    .ADDR_W(3), .DATA_W(8), .SETUP_CYC(3), .PULSE_CYC(4), .HOLD_CYC(2)
  ) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus0(input string tag, input logic ncs, input logic nwr, input logic nrd,
                          input logic doe, input logic ack, input logic busy);
    check({tag, ".ncs"},  32'(bus0.ncs_o),  32'(ncs));
    check({tag, ".nwr"},  32'(bus0.nwr_o),  32'(nwr));
    check({tag, ".nrd"},  32'(bus0.nrd_o),  32'(nrd));
    check({tag, ".doe"},  32'(bus0.d_oe_o), 32'(doe));
    check({tag, ".ack"},  32'(bus0.ack_o),  32'(ack));
    check({tag, ".busy"}, 32'(bus0.busy_o), 32'(busy));
  endtask

  task automatic chk_ad0(input string tag, input logic [2:0] a, input logic [7:0] d);
    check({tag, ".a"}, 32'(bus0.a_o),     32'(a));
    check({tag, ".d"}, 32'(bus0.d_out_o), 32'(d));
  endtask

  initial begin
    int nrd_low;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus0.req_i = 1'b0; bus0.we_i = 1'b0; bus0.addr_i = '0; bus0.wdata_i = '0; bus0.d_in_i = '0;
    bus1.req_i = 1'b0; bus1.we_i = 1'b0; bus1.addr_i = '0; bus1.wdata_i = '0; bus1.d_in_i = '0;
    repeat (2) tick();

    // reset state of both instances
    chk_bus0("rst", 1, 1, 1, 0, 0, 0);
    chk_ad0("rst", 3'd0, 8'h00);
    check("rst.rdata", 32'(bus0.rdata_o), 32'h0);
    check("rst1.ncs",  32'(bus1.ncs_o),   32'h1);
    check("rst1.nrd",  32'(bus1.nrd_o),   32'h1);
    check("rst1.busy", 32'(bus1.busy_o),  32'h0);
    rst = 1'b0;
    repeat (2) tick();

    // write ADDR=5 WDATA=A7; request inputs scrambled after acceptance
    bus0.req_i = 1'b1; bus0.we_i = 1'b1; bus0.addr_i = 3'd5; bus0.wdata_i = 8'hA7;
    tick();
    bus0.req_i = 1'b0; bus0.addr_i = 3'd0; bus0.wdata_i = 8'h00;
    chk_bus0("wr0", 0, 1, 1, 1, 0, 1); chk_ad0("wr0", 3'd5, 8'hA7);
    tick(); chk_bus0("wr1", 0, 0, 1, 1, 0, 1); chk_ad0("wr1", 3'd5, 8'hA7);
    tick(); chk_bus0("wr2", 0, 0, 1, 1, 0, 1);
    tick(); chk_bus0("wr3", 0, 1, 1, 1, 0, 1); chk_ad0("wr3", 3'd5, 8'hA7);
    tick(); chk_bus0("wr4", 1, 1, 1, 0, 1, 0); chk_ad0("wr4", 3'd5, 8'hA7);
    check("wr4.rdata", 32'(bus0.rdata_o), 32'h0);
    tick(); chk_bus0("wr5", 1, 1, 1, 0, 0, 0);

    // read ADDR=3 with D_IN=5C held
    bus0.d_in_i = 8'h5C;
    bus0.req_i = 1'b1; bus0.we_i = 1'b0; bus0.addr_i = 3'd3;
    tick();
    bus0.req_i = 1'b0;
    chk_bus0("rd0", 0, 1, 1, 0, 0, 1); check("rd0.a", 32'(bus0.a_o), 32'd3);
    tick(); chk_bus0("rd1", 0, 1, 0, 0, 0, 1);
    tick(); chk_bus0("rd2", 0, 1, 0, 0, 0, 1);
    tick(); chk_bus0("rd3", 0, 1, 1, 0, 0, 1);
    tick(); chk_bus0("rd4", 1, 1, 1, 0, 1, 0);
    check("rd4.rdata", 32'(bus0.rdata_o), 32'h5C);
    check("rd4.d", 32'(bus0.d_out_o), 32'hA7);
    bus0.d_in_i = 8'h00;
    tick(); chk_bus0("rd5", 1, 1, 1, 0, 0, 0);
    check("rd5.rdata", 32'(bus0.rdata_o), 32'h5C);

    // REQ held high: two back-to-back writes with a one-cycle nCS gap
    bus0.req_i = 1'b1; bus0.we_i = 1'b1; bus0.addr_i = 3'd1; bus0.wdata_i = 8'h11;
    tick();
    bus0.addr_i = 3'd2; bus0.wdata_i = 8'h22;
    chk_bus0("bb0", 0, 1, 1, 1, 0, 1); chk_ad0("bb0", 3'd1, 8'h11);
    repeat (3) tick();
    chk_ad0("bb3", 3'd1, 8'h11);
    tick(); chk_bus0("bb4", 1, 1, 1, 0, 1, 0);
    tick(); chk_bus0("bb5", 0, 1, 1, 1, 0, 1); chk_ad0("bb5", 3'd2, 8'h22);
    bus0.req_i = 1'b0;
    repeat (3) tick();
    tick(); chk_bus0("bb9", 1, 1, 1, 0, 1, 0);
    check("bb9.rdata", 32'(bus0.rdata_o), 32'h5C);
    tick(); chk_bus0("bb10", 1, 1, 1, 0, 0, 0);
    tick(); chk_bus0("bb11", 1, 1, 1, 0, 0, 0);

    // REQ pulses while busy are ignored
    bus0.req_i = 1'b1; bus0.we_i = 1'b1; bus0.addr_i = 3'd4; bus0.wdata_i = 8'h44;
    tick();
    bus0.we_i = 1'b0; bus0.addr_i = 3'd7; bus0.wdata_i = 8'h77;
    tick(); chk_bus0("ig1", 0, 0, 1, 1, 0, 1); chk_ad0("ig1", 3'd4, 8'h44);
    tick(); chk_ad0("ig2", 3'd4, 8'h44);
    tick(); chk_bus0("ig3", 0, 1, 1, 1, 0, 1); chk_ad0("ig3", 3'd4, 8'h44);
    tick(); chk_bus0("ig4", 1, 1, 1, 0, 1, 0);
    bus0.req_i = 1'b0;
    for (int k = 5; k < 8; k++) begin
      tick();
      chk_bus0($sformatf("ig%0d", k), 1, 1, 1, 0, 0, 0);
    end

    // reset in the middle of a write strobe aborts without a clock edge
    bus0.req_i = 1'b1; bus0.we_i = 1'b1; bus0.addr_i = 3'd6; bus0.wdata_i = 8'h66;
    tick();
    bus0.req_i = 1'b0;
    tick(); chk_bus0("ab1", 0, 0, 1, 1, 0, 1);
    #2 rst = 1'b1;
    #1;
    chk_bus0("ab_rst", 1, 1, 1, 0, 0, 0); chk_ad0("ab_rst", 3'd0, 8'h00);
    check("ab_rst.rdata", 32'(bus0.rdata_o), 32'h0);
    #1 rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_bus0($sformatf("ab_idle%0d", k), 1, 1, 1, 0, 0, 0);
    end
    bus0.req_i = 1'b1; bus0.we_i = 1'b1; bus0.addr_i = 3'd2; bus0.wdata_i = 8'h5A;
    tick();
    bus0.req_i = 1'b0;
    chk_bus0("ab_nx0", 0, 1, 1, 1, 0, 1); chk_ad0("ab_nx0", 3'd2, 8'h5A);
    tick(); chk_bus0("ab_nx1", 0, 0, 1, 1, 0, 1);
    repeat (2) tick();
    tick(); chk_bus0("ab_nx4", 1, 1, 1, 0, 1, 0);

    // stretched 3/4/2 read: D_IN changes one cycle before the final nRD-low edge
    bus1.d_in_i = 8'h11;
    bus1.req_i = 1'b1; bus1.we_i = 1'b0; bus1.addr_i = 3'd6;
    tick();
    bus1.req_i = 1'b0;
    check("s0.ncs",  32'(bus1.ncs_o),  32'h0);
    check("s0.nrd",  32'(bus1.nrd_o),  32'h1);
    check("s0.busy", 32'(bus1.busy_o), 32'h1);
    check("s0.a",    32'(bus1.a_o),    32'd6);
    nrd_low = 0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (bus1.nrd_o === 1'b0) nrd_low++;
      check($sformatf("s%0d.ncs", k), 32'(bus1.ncs_o), (k <= 8) ? 32'h0 : 32'h1);
      check($sformatf("s%0d.nrd", k), 32'(bus1.nrd_o), (k >= 3 && k <= 6) ? 32'h0 : 32'h1);
      check($sformatf("s%0d.nwr", k), 32'(bus1.nwr_o), 32'h1);
      check($sformatf("s%0d.ack", k), 32'(bus1.ack_o), (k == 9) ? 32'h1 : 32'h0);
      check($sformatf("s%0d.doe", k), 32'(bus1.d_oe_o), 32'h0);
      check($sformatf("s%0d.rdata", k), 32'(bus1.rdata_o), (k >= 7) ? 32'hC3 : 32'h0);
      if (k == 6) bus1.d_in_i = 8'hC3;
    end
    check("s.width", 32'(nrd_low), 32'd4);
    tick();
    check("s10.ack",  32'(bus1.ack_o),  32'h0);
    check("s10.busy", 32'(bus1.busy_o), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
